// File: rtl/fibo_bcd_converter_if.sv
// Operand/result bundle between the Fibonacci datapath and
// the BCD converter feeding the 7-segment driver.
interface fibo_bcd_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic                  busy;
  logic                  done;
  logic                  valid;

  modport master (
    output start,
    output bin,
    input  bcd,
    input  overflow,
    input  busy,
    input  done,
    input  valid
  );

  modport slave (
    input  start,
    input  bin,
    output bcd,
    output overflow,
    output busy,
    output done,
    output valid
  );
endinterface

// File: rtl/fibo_bcd_converter.sv
// Sequential shift-and-add-3 binary to packed BCD converter,
// one operand bit per clock, sticky overflow past DIGITS.
module fibo_bcd_converter #(
  parameter int WIDTH      = 32,
  parameter int DIGITS     = 8,
  parameter bit CONTINUOUS = 1'b0
) (
  input logic       clk,
  input logic       reset,
  fibo_bcd_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] last;
  logic [BW-1:0]    work;
  logic [BW-1:0]    adj;
  logic             sticky;
  logic [CW-1:0]    cnt;
  logic             trig;

  logic [BW-1:0]    bcd_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic             valid_q;

  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.valid    = valid_q;

  assign trig = bus.start
              | (CONTINUOUS & (bus.bin != last));

  // Per-digit +3 correction, no carry between digits.
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      opnd    <= '0;
      last    <= '0;
      work    <= '0;
      sticky  <= 1'b0;
      cnt     <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig) begin
            opnd   <= bus.bin;
            last   <= bus.bin;
            work   <= '0;
            sticky <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {work, opnd} <= {adj[BW-2:0], opnd, 1'b0};
          // Any bit leaving the top digit means >= 10^DIGITS.
          sticky <= sticky | adj[BW-1];
          cnt    <= cnt + 1'b1;
          if (cnt == LAST)
            state <= FINISH;
        end
        FINISH: begin
          bcd_q   <= work;
          ovf_q   <= sticky;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_bcd_converter.sv
// Self-checking bench for fibo_bcd_converter: fixed vectors,
// random operands against a decimal model, and timing corners.
module tb_fibo_bcd_converter;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  fibo_bcd_if #(.WIDTH(32), .DIGITS(8)) bus0 ();
  fibo_bcd_if #(.WIDTH(32), .DIGITS(8)) bus1 ();

  fibo_bcd_converter #(
    .WIDTH(32), .DIGITS(8), .CONTINUOUS(1'b0)
  ) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  fibo_bcd_converter #(
    .WIDTH(32), .DIGITS(8), .CONTINUOUS(1'b1)
  ) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: value mod 10^8, overflow if >= 10^8.
  function automatic void model(input  logic [31:0] v,
                                output logic [31:0] b,
                                output logic        o);
    longint x;
    x = longint'(v);
    o = (x >= 64'd100000000);
    x = x % 100000000;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
  endfunction

  task automatic conv(input  logic [31:0] v,
                      output logic [31:0] b,
                      output logic        o,
                      output int          lat,
                      output int          bz);
    int k;
    @(negedge clk);
    bus0.bin   = v;
    bus0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.start = 1'b0;
    k  = 0;
    bz = 0;
    while (!bus0.done && k < 40) begin
      if (bus0.busy) bz++;
      @(negedge clk);
      k++;
    end
    lat = k;
    b   = bus0.bcd;
    o   = bus0.overflow;
  endtask

  initial begin
    vec_t        vt[7];
    logic [31:0] b;
    logic [31:0] eb;
    logic        o;
    logic        eo;
    int          lat;
    int          bz;
    int          k;
    int          nd;
    logic [31:0] seq[6];

    tests = 0;
    fails = 0;
    vt[0] = '{32'd12345678,  32'h12345678, 1'b0};
    vt[1] = '{32'd99999999,  32'h99999999, 1'b0};
    vt[2] = '{32'd100000000, 32'h00000000, 1'b1};
    vt[3] = '{32'hFFFFFFFF,  32'h94967295, 1'b1};
    vt[4] = '{32'd2971215073,32'h71215073, 1'b1};
    vt[5] = '{32'd832040,    32'h00832040, 1'b0};
    vt[6] = '{32'd1,         32'h00000001, 1'b0};
    seq = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8};

    bus0.start = 1'b0;
    bus0.bin   = '0;
    bus1.start = 1'b0;
    bus1.bin   = '0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("reset_bcd",   bus0.bcd, 0);
    chk("reset_ovf",   bus0.overflow, 0);
    chk("reset_busy",  bus0.busy, 0);
    chk("reset_done",  bus0.done, 0);
    chk("reset_valid", bus0.valid, 0);

    conv(32'd0, b, o, lat, bz);
    chk("zero_latency", lat, 33);
    chk("zero_busy_cycles", bz, 33);
    chk("zero_busy_at_done", bus0.busy, 0);
    chk("zero_bcd", b, 0);
    chk("zero_ovf", o, 0);
    chk("zero_valid", bus0.valid, 1);
    @(negedge clk);
    chk("done_one_cycle", bus0.done, 0);

    for (int i = 0; i < 7; i++) begin
      conv(vt[i].bin, b, o, lat, bz);
      chk($sformatf("vec%0d_lat", i), lat, 33);
      chk($sformatf("vec%0d_bcd", i), b, vt[i].bcd);
      chk($sformatf("vec%0d_ovf", i), o, vt[i].ovf);
    end

    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = (i % 2 == 0) ? $urandom
                       : $urandom_range(0, 99999999);
      model(v, eb, eo);
      conv(v, b, o, lat, bz);
      chk($sformatf("rnd%0d_bcd(%0d)", i, v), b, eb);
      chk($sformatf("rnd%0d_ovf", i), o, eo);
    end

    // Inputs changing mid-conversion are ignored.
    @(negedge clk);
    bus0.bin   = 32'd55;
    bus0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.start = 1'b0;
    k  = 0;
    nd = 0;
    while (k < 40) begin
      if (bus0.done) begin
        nd++;
        if (nd == 1) begin
          chk("ignore_latency", k, 33);
          chk("ignore_bcd", bus0.bcd, 32'h55);
        end
      end
      if (k == 4 || k == 19) begin
        bus0.start = 1'b1;
        bus0.bin   = 32'd89;
      end else begin
        bus0.start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    chk("ignore_single_done", nd, 1);
    chk("ignore_idle", bus0.busy, 0);
    chk("ignore_bcd_hold", bus0.bcd, 32'h55);

    // Back-to-back with start held high.
    @(negedge clk);
    bus0.bin   = 32'd7;
    bus0.start = 1'b1;
    k = 0;
    while (!bus0.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_first_done", bus0.done, 1);
    k = 0;
    @(negedge clk);
    k++;
    while (!bus0.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    bus0.start = 1'b0;
    chk("b2b_period", k, 34);
    chk("b2b_bcd", bus0.bcd, 32'h7);
    repeat (3) @(negedge clk);
    chk("b2b_stops", bus0.busy, 0);

    // Reset mid-conversion abandons it.
    @(negedge clk);
    bus0.bin   = 32'd832040;
    bus0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy",  bus0.busy, 0);
    chk("midrst_bcd",   bus0.bcd, 0);
    chk("midrst_valid", bus0.valid, 0);
    chk("midrst_done",  bus0.done, 0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus0.done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    conv(32'd832040, b, o, lat, bz);
    chk("midrst_reconv_bcd", b, 32'h00832040);
    chk("midrst_reconv_ovf", o, 0);

    // Reset and start in the same cycle: reset wins.
    @(negedge clk);
    reset      = 1'b1;
    bus0.start = 1'b1;
    bus0.bin   = 32'd5;
    @(negedge clk);
    reset      = 1'b0;
    bus0.start = 1'b0;
    chk("rststart_busy", bus0.busy, 0);
    @(negedge clk);
    chk("rststart_still_idle", bus0.busy, 0);
    chk("rststart_valid", bus0.valid, 0);

    // Continuous mode: one conversion per operand change.
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus1.bin = seq[i];
      repeat (40) begin
        @(negedge clk);
        if (bus1.done) nd++;
      end
    end
    chk("cont_done_count", nd, 5);
    chk("cont_bcd", bus1.bcd, 32'h8);
    chk("cont_ovf", bus1.overflow, 0);
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus1.done) nd++;
    end
    chk("cont_explicit_start", nd, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
